// File: rtl/deintlv_bit_buf.sv
// deintlv_bit_buf: two-bank ping-pong bit buffer, permuted-address writes in, sequential bits out.
// Ports: clk/reset (sync, active-high); write side wr_valid/wr_ready/wr_addr/wr_data/wr_last;
// read side rd_valid/rd_ready/rd_data/rd_last; err_o sticky flag for writes with wr_addr >= DEPTH.
// Build option: define DEINTLV_CLEAR_EN to zero each cell as it is read and all cells at reset,
// so cells left unwritten in a block read back as 0 (erasure/depuncture positions).
module deintlv_bit_buf #(
  parameter int DEPTH = 288,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic          wr_last,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_data,
  output logic          rd_last,
  output logic          err_o
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_t;
  localparam logic [AW:0] DMAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [DEPTH-1:0] mem [2];
  bank_st_t st [2];
  bank_st_t st_nx [2];
  logic [AW:0] len [2];
  logic [AW:0] wr_cnt, rd_ptr, cnt_inc;
  logic wr_bank, rd_bank, wr_go, rd_go, addr_ok;
  assign wr_go = wr_valid & wr_ready;
  assign rd_go = rd_valid & rd_ready;
  assign addr_ok = {1'b0, wr_addr} < DMAX;
  // count of accepts including the current one, saturated at DEPTH
  assign cnt_inc = (wr_cnt == DMAX) ? DMAX : wr_cnt + ONE;
  always_ff @(posedge clk) begin
    if (reset) st <= '{EMPTY, EMPTY};
    else st <= st_nx;
  end
  // the write bank is never FULL and the read bank always is, so the two
  // updates below can never target the same bank in one cycle
  always_comb begin
    st_nx = st;
    if (wr_go && addr_ok && st[wr_bank] == EMPTY) st_nx[wr_bank] = FILLING;
    if (wr_go && wr_last) st_nx[wr_bank] = FULL;
    if (rd_go && rd_last) st_nx[rd_bank] = EMPTY;
  end
  always_comb begin
    wr_ready = st[wr_bank] != FULL;
    rd_valid = st[rd_bank] == FULL;
    rd_last = rd_valid && rd_ptr == len[rd_bank] - ONE;
    rd_data = rd_valid & mem[rd_bank][rd_ptr[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt <= '0;
      rd_ptr <= '0;
      err_o <= 1'b0;
      len <= '{default: '0};
    end else begin
      if (wr_go) begin
        wr_cnt <= wr_last ? '0 : cnt_inc;
        if (wr_last) len[wr_bank] <= cnt_inc;
        if (wr_last) wr_bank <= ~wr_bank;
        if (!addr_ok) err_o <= 1'b1;
      end
      if (rd_go) begin
        rd_ptr <= rd_last ? '0 : rd_ptr + ONE;
        if (rd_last) rd_bank <= ~rd_bank;
      end
    end
  end
  always_ff @(posedge clk) begin
`ifdef DEINTLV_CLEAR_EN
    if (reset) mem <= '{default: '0};
    else begin
      if (wr_go && addr_ok) mem[wr_bank][wr_addr] <= wr_data;
      if (rd_go) mem[rd_bank][rd_ptr[AW-1:0]] <= 1'b0;
    end
`else
    if (wr_go && addr_ok) mem[wr_bank][wr_addr] <= wr_data;
`endif
  end
endmodule

// File: tb/tb_deintlv_bit_buf.sv
// tb_deintlv_bit_buf: scoreboard bench for deintlv_bit_buf; expected in-order bits are queued at each wr_last accept.
module tb_deintlv_bit_buf;
  localparam int DEPTH = 288;
`ifdef DEINTLV_CLEAR_EN
  localparam int EXP_ONES = 24;
`else
  localparam int EXP_ONES = 48;
`endif
  logic clk = 0, reset = 1, wr_valid = 0, wr_data = 0, wr_last = 0, rd_ready = 0;
  logic [8:0] wr_addr = '0;
  logic wr_ready, rd_valid, rd_data, rd_last, err_o;
  int checks = 0, fails = 0;
  bit mm [2][DEPTH];
  bit mwb;
  int mcnt;
  int perm [DEPTH];
  logic [1:0] q [$];
  logic [1:0] e;
  logic wacc, rx;

  deintlv_bit_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic shuffle(input int n);
    for (int i = 0; i < n; i++) perm[i] = i;
    for (int i = n - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  task automatic rst_dut;
    @(negedge clk);
    reset = 1; wr_valid = 0; wr_last = 0; rd_ready = 0;
    @(negedge clk);
    reset = 0;
    #1;
    q.delete(); mwb = 0; mcnt = 0;
`ifdef DEINTLV_CLEAR_EN
    foreach (mm[i, j]) mm[i][j] = 1'b0;
`endif
  endtask

  // drive one cycle of inputs at the falling edge; record whether the coming
  // rising edge accepts a write / transfers a read, and update the model
  task automatic tick(input bit v, input int a, input bit d, input bit l, input bit rr);
    @(negedge clk);
    wr_valid = v; wr_addr = 9'(a); wr_data = d; wr_last = l; rd_ready = rr;
    #1;
    wacc = v && wr_ready;
    rx = rd_valid && rr;
    if (wacc) begin
      if (a < DEPTH) mm[mwb][a] = d;
      if (mcnt < DEPTH) mcnt++;
      if (l) begin
        for (int i = 0; i < mcnt; i++) begin
          q.push_back({mm[mwb][i], 1'(i == mcnt - 1)});
`ifdef DEINTLV_CLEAR_EN
          mm[mwb][i] = 1'b0;
`endif
        end
        mcnt = 0; mwb = ~mwb;
      end
    end
  endtask

  task automatic test_reset;
    rst_dut();
    checks++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (rd_last !== 1'b0) begin fails++; $display("FAIL reset_rd_last: got %b want 0", rd_last); end
    checks++; if (rd_data !== 1'b0) begin fails++; $display("FAIL reset_rd_data: got %b want 0", rd_data); end
    checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_o); end
  endtask

  task automatic test_basic;
    int a [4] = '{3, 1, 0, 2};
    bit d [4] = '{1, 0, 1, 1};
    rst_dut();
    for (int i = 0; i < 4; i++) begin
      tick(1, a[i], d[i], i == 3, 0);
      checks++; if (wacc !== 1'b1) begin fails++; $display("FAIL basic_wr_ready: got %b want 1", wr_ready); end
    end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 1'b1) begin
      fails++; $display("FAIL basic_avail: got valid/data %b%b want 11", rd_valid, rd_data);
    end
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      tick(0, 0, 0, 0, 1);
      if (rx) begin
        checks++; e = q.pop_front();
        if ({rd_data, rd_last} !== e) begin fails++; $display("FAIL basic_rd: got data/last %b want %b", {rd_data, rd_last}, e); end
      end
    end
    checks++; if (q.size() != 0) begin fails++; $display("FAIL basic_drain: %0d bits left want 0", q.size()); end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
      fails++; $display("FAIL basic_empty: got valid/ready %b%b want 01", rd_valid, wr_ready);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0, rej = 0;
    int lastpos [$];
    bit freed_chk = 0;
    for (int b = 0; b < 2; b++) begin
      shuffle(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        tick(1, perm[i], 1'($urandom), i == DEPTH - 1, 0);
        if (!wacc) rej++;
      end
    end
    checks++; if (rej != 0) begin fails++; $display("FAIL b2b_rejects: got %0d want 0", rej); end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (wr_ready !== 1'b0 || rd_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_full: got ready/valid %b%b want 01", wr_ready, rd_valid);
    end
    for (int c = 0; c < 700 && n < 2 * DEPTH; c++) begin
      tick(0, 0, 0, 0, 1);
      if (freed_chk) begin
        checks++; freed_chk = 0;
        if (wr_ready !== 1'b1) begin fails++; $display("FAIL b2b_freed: got %b want 1", wr_ready); end
      end
      if (rx) begin
        checks++; e = 2'bxx;
        if (q.size() > 0) e = q.pop_front();
        if ({rd_data, rd_last} !== e) begin fails++; $display("FAIL b2b_rd %0d: got data/last %b want %b", n, {rd_data, rd_last}, e); end
        n++;
        if (rd_last) begin
          lastpos.push_back(n);
          if (lastpos.size() == 1) begin
            checks++; freed_chk = 1;
            if (wr_ready !== 1'b0) begin fails++; $display("FAIL b2b_hold: got %b want 0", wr_ready); end
          end
        end
      end
    end
    checks++; if (n != 2 * DEPTH) begin fails++; $display("FAIL b2b_count: got %0d want %0d", n, 2 * DEPTH); end
    checks++;
    if (lastpos.size() != 2 || lastpos[0] != DEPTH || lastpos[1] != 2 * DEPTH) begin
      fails++; $display("FAIL b2b_lastpos: got %p want 288,576", lastpos);
    end
  endtask

  task automatic test_stream;
    int sa [1920];
    bit sd [1920];
    int wi = 0, nr = 0, stalls = 0;
    for (int b = 0; b < 10; b++) begin
      shuffle(192);
      for (int i = 0; i < 192; i++) begin
        sa[b * 192 + i] = perm[i];
        sd[b * 192 + i] = 1'($urandom);
      end
    end
    for (int c = 0; c < 5000 && (wi < 1920 || nr < 1920); c++) begin
      if (wi < 1920) tick(1, sa[wi], sd[wi], wi % 192 == 191, 1);
      else tick(0, 0, 0, 0, 1);
      if (wi < 1920 && !wr_ready) stalls++;
      if (wacc) wi++;
      if (rx) begin
        checks++; e = 2'bxx;
        if (q.size() > 0) e = q.pop_front();
        if ({rd_data, rd_last} !== e) begin fails++; $display("FAIL stream_rd %0d: got data/last %b want %b", nr, {rd_data, rd_last}, e); end
        nr++;
      end
    end
    checks++; if (stalls != 0) begin fails++; $display("FAIL stream_stall: got %0d stall cycles want 0", stalls); end
    checks++; if (nr != 1920) begin fails++; $display("FAIL stream_count: got %0d want 1920", nr); end
  endtask

  task automatic test_err;
    int a [8] = '{0, 1, 2, 300, 3, 4, 5, 6};
    for (int i = 0; i < 8; i++) begin
      tick(1, a[i], a[i] == 300, i == 7, 0);
      if (i == 3) begin
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_pre: got %b want 0", err_o); end
      end
      if (i == 4) begin
        checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", err_o); end
      end
    end
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      tick(0, 0, 0, 0, 1);
      if (rx) begin
        checks++; e = q.pop_front();
        if ({rd_data, rd_last} !== e) begin fails++; $display("FAIL err_rd: got data/last %b want %b", {rd_data, rd_last}, e); end
      end
    end
    checks++; if (q.size() != 0) begin fails++; $display("FAIL err_drain: %0d bits left want 0", q.size()); end
    tick(0, 0, 0, 0, 0);
    checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", err_o); end
  endtask

  task automatic test_reset_mid;
    int a [4] = '{0, 1, 3, 3};
    int nr = 0;
    rst_dut();
    for (int i = 0; i < 4; i++) tick(1, i, 1, i == 3, 0);
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      tick(0, 0, 0, 0, 1);
      if (rx) begin
        checks++; e = q.pop_front();
        if ({rd_data, rd_last} !== e) begin fails++; $display("FAIL rmid_fill_rd: got data/last %b want %b", {rd_data, rd_last}, e); end
      end
    end
    for (int i = 0; i < 16; i++) tick(1, i < 15 ? i : 400, 0, i == 15, 0);
    for (int c = 0; c < 20 && nr < 8; c++) begin
      tick(0, 0, 0, 0, 1);
      if (rx) begin
        checks++; e = q.pop_front();
        if ({rd_data, rd_last} !== e) begin fails++; $display("FAIL rmid_half_rd: got data/last %b want %b", {rd_data, rd_last}, e); end
        nr++;
      end
    end
    checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL rmid_err_pre: got %b want 1", err_o); end
    rst_dut();
    checks++;
    if (rd_valid !== 1'b0 || wr_ready !== 1'b1 || err_o !== 1'b0 || rd_last !== 1'b0) begin
      fails++; $display("FAIL rmid_after: got valid/ready/err/last %b%b%b%b want 0100", rd_valid, wr_ready, err_o, rd_last);
    end
    for (int i = 0; i < 4; i++) tick(1, a[i], 0, i == 3, 0);
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      tick(0, 0, 0, 0, 1);
      if (rx) begin
        checks++; e = q.pop_front();
        if ({rd_data, rd_last} !== e) begin fails++; $display("FAIL rmid_new_rd: got data/last %b want %b", {rd_data, rd_last}, e); end
      end
    end
    checks++; if (q.size() != 0) begin fails++; $display("FAIL rmid_drain: %0d bits left want 0", q.size()); end
  endtask

  task automatic test_clear;
    int ones = 0, nr = 0;
    rst_dut();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 48; i++) tick(1, i, 1, i == 47, 0);
      for (int c = 0; c < 60 && q.size() > 0; c++) begin
        tick(0, 0, 0, 0, 1);
        if (rx) begin
          checks++; e = q.pop_front();
          if ({rd_data, rd_last} !== e) begin fails++; $display("FAIL clear_a_rd: got data/last %b want %b", {rd_data, rd_last}, e); end
        end
      end
    end
    for (int i = 0; i < 48; i++) tick(1, (i % 24) * 2, 1, i == 47, 0);
    for (int c = 0; c < 60 && nr < 48; c++) begin
      tick(0, 0, 0, 0, 1);
      if (rx) begin
        checks++; e = 2'bxx;
        if (q.size() > 0) e = q.pop_front();
        if ({rd_data, rd_last} !== e) begin fails++; $display("FAIL clear_b_rd %0d: got data/last %b want %b", nr, {rd_data, rd_last}, e); end
        nr++;
        if (rd_data === 1'b1) ones++;
      end
    end
    checks++; if (nr != 48) begin fails++; $display("FAIL clear_count: got %0d want 48", nr); end
    checks++; if (ones != EXP_ONES) begin fails++; $display("FAIL clear_ones: got %0d want %0d", ones, EXP_ONES); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stream();
    test_err();
    test_reset_mid();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
